// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants and the saturation classifier for the systolic MAC grid.
// The classifier is only referenced when SATURATE_EN is defined.
package tpu_pkg;
  localparam int BITS_AB = 8;
  localparam int BITS_C = 16;
  localparam int DIM = 8;
  localparam int ROW_W = $clog2(DIM);

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

  // top = the two MSBs of a one-bit-wider sum; differing bits mean overflow
  function automatic sat_e sat_kind(input logic [1:0] top);
    sat_e k;
    k = SAT_NONE;
    if (top == 2'b01) k = SAT_POS;
    if (top == 2'b10) k = SAT_NEG;
    return k;
  endfunction
endpackage

// File: rtl/tpumac.sv
// tpumac: one systolic cell; forwards A right and B down, accumulates A*B into C.
// Define SATURATE_EN to clamp the accumulator instead of wrapping.
module tpumac #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int BITS_C = tpu_pkg::BITS_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);
  import tpu_pkg::*;
  logic signed [BITS_AB-1:0] a_q, a_d, b_q, b_d;
  logic signed [BITS_C-1:0] c_q, c_d, acc;
  logic signed [2*BITS_AB-1:0] prod;
`ifdef SATURATE_EN
  logic signed [BITS_C:0] sum;
  sat_e sk;
`endif
  always_comb begin
    prod = Ain * Bin;
`ifdef SATURATE_EN
    sum = (BITS_C+1)'(c_q) + (BITS_C+1)'(prod);
    sk = sat_kind(sum[BITS_C -: 2]);
    acc = sk == SAT_POS ? {1'b0, {(BITS_C-1){1'b1}}} :
          sk == SAT_NEG ? {1'b1, {(BITS_C-1){1'b0}}} : sum[BITS_C-1:0];
`else
    acc = c_q + BITS_C'(prod);
`endif
    a_d = en ? Ain : a_q;
    b_d = en ? Bin : b_q;
    c_d = WrEn ? Cin : en ? acc : c_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end
  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = c_q;
endmodule

// File: rtl/systolic_array.sv
// systolic_array: DIMxDIM output-stationary MAC grid with row preload and combinational row readback.
// SATURATE_EN (see tpumac) selects saturating accumulation.
module systolic_array #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int BITS_C = tpu_pkg::BITS_C,
  parameter int DIM = tpu_pkg::DIM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          WrEn,
  input  logic [DIM-1:0][BITS_AB-1:0]   A,
  input  logic [DIM-1:0][BITS_AB-1:0]   B,
  input  logic [$clog2(DIM)-1:0]        Crow,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic [DIM-1:0][BITS_C-1:0]    Cout
);
  localparam int ROW_W = $clog2(DIM);
  logic [BITS_AB-1:0] a_w [DIM][DIM];
  logic [BITS_AB-1:0] b_w [DIM][DIM];
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0] c_w;
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [BITS_AB-1:0] ain, bin;
      if (c == 0) begin : g_a0
        assign ain = A[r];
      end else begin : g_an
        assign ain = a_w[r][c-1];
      end
      if (r == 0) begin : g_b0
        assign bin = B[c];
      end else begin : g_bn
        assign bin = b_w[r-1][c];
      end
      tpumac #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .WrEn (WrEn && Crow == ROW_W'(r)),
        .Ain  (ain),
        .Bin  (bin),
        .Cin  (Cin[c]),
        .Aout (a_w[r][c]),
        .Bout (b_w[r][c]),
        .Cout (c_w[r][c])
      );
    end
  end
  // out-of-range Crow matches no row and reads zero
  always_comb begin
    Cout = '0;
    for (int i = 0; i < DIM; i++) Cout = Crow == ROW_W'(i) ? c_w[i] : Cout;
  end
endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed checks of reset, single products, preload/override, overflow and skewed matmul.
module tb_systolic_array;
  localparam int BITS_AB = 8;
  localparam int BITS_C = 16;
  localparam int DIM = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic WrEn = 1'b0;
  logic [DIM-1:0][BITS_AB-1:0] A = '0;
  logic [DIM-1:0][BITS_AB-1:0] B = '0;
  logic [2:0] Crow = '0;
  logic [DIM-1:0][BITS_C-1:0] Cin = '0;
  logic [DIM-1:0][BITS_C-1:0] Cout;
  int n_chk = 0;
  int n_fail = 0;
  int am[DIM][DIM], bm[DIM][DIM], row_exp[DIM];

  always #5 clk = ~clk;

  systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .A(A), .B(B),
    .Crow(Crow), .Cin(Cin), .Cout(Cout)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input int r);
    Crow = 3'(r);
    #1;
    for (int c = 0; c < DIM; c++)
      check($sformatf("%s r%0d c%0d", tag, r, c), int'($signed(Cout[c])), row_exp[c]);
  endtask

  task automatic run_mm(input string tag);
    int s;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    en = 1'b1;
    for (int t = 0; t < 3*DIM-2; t++) begin
      for (int i = 0; i < DIM; i++) begin
        A[i] = (t-i >= 0 && t-i < DIM) ? 8'(am[i][t-i]) : 8'd0;
        B[i] = (t-i >= 0 && t-i < DIM) ? 8'(bm[t-i][i]) : 8'd0;
      end
      tick;
    end
    en = 1'b0;
    A = '0;
    B = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) s += am[i][k] * bm[k][j];
        row_exp[j] = int'($signed(16'(s)));
      end
      check_row(tag, i);
    end
  endtask

  initial begin
    tick;
    row_exp = '{default: 0};
    for (int r = 0; r < DIM; r++) check_row("reset", r);
    rst_n = 1'b1;
    tick;
    // single product: 3*4 in cell (0,0), then 3*5 one hop right
    en = 1'b1; A[0] = 8'd3; B[0] = 8'd4;
    tick;
    A = '0; B = '0; B[1] = 8'd5;
    tick;
    en = 1'b0; B = '0;
    row_exp = '{12, 15, 0, 0, 0, 0, 0, 0};
    check_row("single", 0);
    A = {DIM{8'h11}}; B = {DIM{8'h22}};
    repeat (5) tick;
    A = '0; B = '0;
    check_row("hold", 0);
    row_exp = '{default: 0};
    check_row("hold", 1);
    // preload row 2 with -7
    WrEn = 1'b1; Crow = 3'd2; Cin = {DIM{16'hFFF9}};
    tick;
    WrEn = 1'b0; Cin = '0;
    row_exp = '{default: -7};
    check_row("preload", 2);
    row_exp = '{12, 15, 0, 0, 0, 0, 0, 0};
    check_row("preload_other", 0);
    // preload of row 2 concurrent with accumulation everywhere
    en = 1'b1; WrEn = 1'b1; Crow = 3'd2;
    A[0] = 8'd2; B[0] = 8'd6; B[2] = 8'd1; A[2] = 8'd9;
    for (int c = 0; c < DIM; c++) Cin[c] = 16'(100 + c);
    tick;
    en = 1'b0; WrEn = 1'b0; A = '0; B = '0; Cin = '0;
    row_exp = '{24, 15, 3, 0, 0, 0, 0, 0};
    check_row("override_acc", 0);
    for (int c = 0; c < DIM; c++) row_exp[c] = 100 + c;
    check_row("override", 2);
    row_exp = '{default: 0};
    check_row("override_r1", 1);
    // asynchronous reset in the middle of accumulation
    en = 1'b1; A = {DIM{8'h03}}; B = {DIM{8'h03}};
    tick;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < DIM; r++) check_row("midreset", r);
    en = 1'b0; A = '0; B = '0;
    tick;
    rst_n = 1'b1;
    tick;
    // overflow at both ends of the accumulator range
    WrEn = 1'b1; Crow = 3'd0; Cin[0] = 16'h7FFF;
    tick;
    WrEn = 1'b0; en = 1'b1; A[0] = 8'd1; B[0] = 8'd1;
    tick;
    en = 1'b0;
    #1;
`ifdef SATURATE_EN
    check("ovf_pos", int'($signed(Cout[0])), 32767);
`else
    check("ovf_pos", int'($signed(Cout[0])), -32768);
`endif
    WrEn = 1'b1; Cin[0] = 16'h8000;
    tick;
    WrEn = 1'b0;
    check("preload_min", int'($signed(Cout[0])), -32768);
    en = 1'b1; A[0] = 8'hFF; B[0] = 8'd1;
    tick;
    en = 1'b0; A = '0; B = '0; Cin = '0;
    #1;
`ifdef SATURATE_EN
    check("ovf_neg", int'($signed(Cout[0])), -32768);
`else
    check("ovf_neg", int'($signed(Cout[0])), 32767);
`endif
    // identity times random B gives B
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        am[i][j] = (i == j) ? 1 : 0;
        bm[i][j] = int'($urandom_range(0, 255)) - 128;
      end
    run_mm("ident");
    // random operands kept small so no accumulator overflow occurs
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        am[i][j] = int'($urandom_range(0, 120)) - 60;
        bm[i][j] = int'($urandom_range(0, 120)) - 60;
      end
    run_mm("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_array.md
# systolic_array

DIM×DIM weight-stationary-free (output-stationary) systolic multiply-accumulate grid that consumes the skewed A row stream and the skewed B column stream produced by the operand staging FIFOs and accumulates C = A·B in place. A operands flow left-to-right, B operands flow top-to-bottom, and each cell keeps its own C accumulator. The accumulators can be preloaded one row at a time, and one selected row can be read back through a row-select port. The block sits directly downstream of the A/B staging memories and upstream of the result writeback logic.

## Interface
- BITS_AB, 8, signed width of A and B operands
- BITS_C, 16, signed width of each C accumulator
- DIM, 8, grid dimension (rows = columns)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  advance operand pipeline and accumulate
- WrEn  in  1  load row Crow accumulators from Cin
- A  in  BITS_AB × DIM, signed  A[r] enters row r, column 0
- B  in  BITS_AB × DIM, signed  B[c] enters column c, row 0
- Crow  in  $clog2(DIM)  row select for write and read
- Cin  in  BITS_C × DIM, signed  preload values for row Crow, element c → column c
- Cout  out  BITS_C × DIM, signed  accumulators of row Crow, element c = column c

## Operation
- Cell (r,c) holds the registers a_q, b_q and c_q.
- Ain of cell (r,c) is A[r] when c=0, otherwise a_q of cell (r,c-1). Bin of cell (r,c) is B[c] when r=0, otherwise b_q of cell (r-1,c).
- On a clock edge with en=1, every cell updates: a_q←Ain, b_q←Bin, c_q←c_q + Ain·Bin.
- Product: the full 2·BITS_AB signed product, sign-extended to BITS_C. The sum wraps modulo 2^BITS_C (two's complement).
- On a clock edge with en=0, all registers hold.
- WrEn=1: on the clock edge, c_q of every cell in row Crow ← Cin[c].
  - This applies regardless of en and overrides any accumulation in that row.
  - a_q/b_q in that row still shift if en=1.
  - All other rows behave normally.
- Cout is combinational: Cout[c] = c_q of cell (Crow,c). There is no read latency.
- Out-of-range Crow (DIM not a power of two, Crow ≥ DIM): writes are ignored and Cout is all zero.
- Reset: every a_q, b_q and c_q clears to 0. Cout therefore reads 0 for any Crow. Reset mid-computation discards all partial sums immediately.

## Timing
- Upstream delivers A row r delayed r cycles and B column c delayed c cycles. Under that skew, element k of A row i meets element k of B column j in cell (i,j).
- With en held high from the first non-zero operand, C[i][j] is final after 3·DIM−2 enabled cycles. For DIM=8 that is 22 cycles.
- Each cell propagates operands one hop per enabled cycle, so operand latency through the grid is DIM−1 cycles per axis.
- Accumulation result is visible on Cout in the cycle after the edge that produced it.
- WrEn followed by a read of the same row: the new value is visible in the cycle after the WrEn edge.
- Throughput: one operand wavefront per enabled cycle. There are no stalls other than en=0.

## Configuration
- SATURATE_EN defined: the accumulate saturates to [−2^(BITS_C−1), 2^(BITS_C−1)−1] instead of wrapping. The saturation detect uses a BITS_C+1-bit intermediate sum.
- SATURATE_EN undefined: the accumulate wraps modulo 2^BITS_C.
- Preload through WrEn is never saturated or altered in either mode.

## Structure
- Shared package tpu_pkg holds:
  - default constants BITS_AB=8, BITS_C=16, DIM=8
  - ROW_W = $clog2(DIM)
  - saturation helper function, used only under SATURATE_EN
- Sub-module tpumac: one cell, containing a_q/b_q/c_q, the MAC, and WrEn/Cin handling.
  - Ports: clk, rst_n, en, WrEn, Ain, Bin, Cin, Aout, Bout, Cout.
  - systolic_array is a 2-D generate of tpumac plus the Crow write decode and the Cout read mux.

## Test plan
- Reset, then Crow swept 0..7 → Cout all 0. Assert rst_n low mid-accumulation → all rows read 0 on the next cycle.
- Single product:
  - Cycle 1: en=1, A[0]=3, B[0]=4. Cycle 2: en=1, all inputs 0 except B[1]=5.
  - Crow=0 → Cout[0]=12, Cout[1]=15, other entries 0.
  - Hold en=0 for 5 cycles → values unchanged.
- Preload and override:
  - WrEn=1, Crow=2, Cin all −7 → row 2 reads −7, other rows unchanged.
  - WrEn on row 2 together with en=1 and non-zero operands → row 2 = Cin, row 0 still accumulates.
- Overflow: preload C[0][0]=32767, then A[0]=1, B[0]=1 with en → −32768 without SATURATE_EN, 32767 with it. Preload −32768 and apply A=−1, B=1 → 32767 wrap, or −32768 when saturated.
- Full matmul:
  - A = identity, B = random signed 8-bit, both fed with upstream skew; en high for 22 cycles.
  - Every row read back → C equals B exactly.
  - Repeat with random A and B against a reference model.
